// File: rtl/parking_gate_scheduler.sv
// Central car-park scheduler: serialises per-gate entry/exit requests, owns the
// occupancy count and grants one barrier opening at a time (exits win over entries).
module parking_gate_scheduler #(
    parameter int NUM_GATES   = 4,
    parameter int CAPACITY    = 16,
    parameter int CNT_W       = 5,
    parameter int OPEN_CYCLES = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic [NUM_GATES-1:0] entry_req,
    input  logic [NUM_GATES-1:0] exit_req,
    output logic [NUM_GATES-1:0] entry_grant,
    output logic [NUM_GATES-1:0] exit_grant,
    output logic [NUM_GATES-1:0] deny,
    output logic                 busy,
    output logic [CNT_W-1:0]     occupancy,
    output logic                 lot_full,
    output logic                 lot_empty
);

    localparam int PTR_W = (NUM_GATES > 1) ? $clog2(NUM_GATES) : 1;
    localparam int OC_W  = (OPEN_CYCLES > 1) ? $clog2(OPEN_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CAP       = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] CAP_M1    = CNT_W'(CAPACITY - 1);
    localparam logic [CNT_W-1:0] ONE       = CNT_W'(1);
    localparam logic [OC_W-1:0]  OPEN_LAST = OC_W'(OPEN_CYCLES - 1);

    typedef enum logic [1:0] {IDLE, OPEN, CLOSE} state_t;

    state_t                 state_q;
    logic [PTR_W-1:0]       entryPtr_q, exitPtr_q;
    logic [PTR_W-1:0]       entryPtr_d, exitPtr_d;
    logic [OC_W-1:0]        openCnt_q;
    logic [CNT_W-1:0]       occ_q;
    logic [NUM_GATES-1:0]   entryGrant_q, exitGrant_q, deny_q;
    logic                   busy_q, full_q, empty_q;

    logic [PTR_W:0]         exitPick, entryPick;
    logic                   exitHit, entryHit;
    logic [PTR_W-1:0]       exitIdx, entryIdx;
    logic [NUM_GATES-1:0]   winOneHot;

    // Round-robin search: lowest offset from ptr wins, so scan offsets high-to-low.
    function automatic logic [PTR_W:0] pick(input logic [NUM_GATES-1:0] req,
                                            input logic [PTR_W-1:0]     ptr);
        logic [PTR_W:0] res;
        int             j;
        res = '0;
        for (int i = NUM_GATES - 1; i >= 0; i--) begin
            j = (int'(ptr) + i) % NUM_GATES;
            if (req[j]) res = {1'b1, PTR_W'(j)};
        end
        return res;
    endfunction

    function automatic logic [PTR_W-1:0] nextPtr(input logic [PTR_W-1:0] idx);
        return (int'(idx) == NUM_GATES - 1) ? '0 : idx + 1'b1;
    endfunction

    always_comb begin
        exitPick   = pick(exit_req, exitPtr_q);
        entryPick  = pick(entry_req, entryPtr_q);
        exitHit    = exitPick[PTR_W];
        exitIdx    = exitPick[PTR_W-1:0];
        entryHit   = entryPick[PTR_W];
        entryIdx   = entryPick[PTR_W-1:0];
        exitPtr_d  = nextPtr(exitIdx);
        entryPtr_d = nextPtr(entryIdx);
        winOneHot  = '0;
        winOneHot[exitHit ? exitIdx : entryIdx] = 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            entryPtr_q   <= '0;
            exitPtr_q    <= '0;
            openCnt_q    <= '0;
            occ_q        <= '0;
            entryGrant_q <= '0;
            exitGrant_q  <= '0;
            deny_q       <= '0;
            busy_q       <= 1'b0;
            full_q       <= 1'b0;
            empty_q      <= 1'b1;
        end else begin
            deny_q <= '0;
            case (state_q)
                IDLE: begin
                    if (exitHit) begin
                        exitPtr_q <= exitPtr_d;
                        if (empty_q) begin
                            deny_q <= winOneHot;
                        end else begin
                            state_q     <= OPEN;
                            busy_q      <= 1'b1;
                            exitGrant_q <= winOneHot;
                            openCnt_q   <= OPEN_LAST;
                            occ_q       <= occ_q - ONE;
                            empty_q     <= (occ_q == ONE);
                            full_q      <= 1'b0;
                        end
                    end else if (entryHit) begin
                        entryPtr_q <= entryPtr_d;
                        if (full_q) begin
                            deny_q <= winOneHot;
                        end else begin
                            state_q      <= OPEN;
                            busy_q       <= 1'b1;
                            entryGrant_q <= winOneHot;
                            openCnt_q    <= OPEN_LAST;
                            occ_q        <= occ_q + ONE;
                            full_q       <= (occ_q == CAP_M1);
                            empty_q      <= 1'b0;
                        end
                    end
                end
                OPEN: begin
                    if (openCnt_q == '0) begin
                        state_q      <= CLOSE;
                        entryGrant_q <= '0;
                        exitGrant_q  <= '0;
                    end else begin
                        openCnt_q <= openCnt_q - 1'b1;
                    end
                end
                CLOSE: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q      <= IDLE;
                    busy_q       <= 1'b0;
                    entryGrant_q <= '0;
                    exitGrant_q  <= '0;
                end
            endcase
        end
    end

    assign entry_grant = entryGrant_q;
    assign exit_grant  = exitGrant_q;
    assign deny        = deny_q;
    assign busy        = busy_q;
    assign occupancy   = occ_q;
    assign lot_full    = full_q;
    assign lot_empty   = empty_q;

    logic unusedCap;
    assign unusedCap = ^CAP;

endmodule
